// File: rtl/apb_router_pkg.sv
// Shared types and helpers for the APB slave router: FSM encoding and
// slot-validity decode.
package apb_router_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ERR    = 2'd2,
        ST_TOUT   = 2'd3
    } state_t;

    // A slot is valid only if it exists and is populated; the mask is
    // passed zero-extended so the helper works for any RATIO up to 32.
    function automatic logic slot_valid(input int unsigned idx,
                                        input int unsigned ratio,
                                        input logic [31:0] mask);
        if ((idx >= ratio) || (idx > 31)) begin
            return 1'b0;
        end
        return mask[idx[4:0]];
    endfunction

endpackage

// File: rtl/apb_to_counter.sv
// Wait-state counter for the ACCESS phase; flags the last allowed wait cycle.
module apb_to_counter #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expired
);

    // TIMEOUT of 0 disables expiry, so LAST is never compared meaningfully.
    localparam logic [TO_W-1:0] LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + TO_W'(1);
        end
    end

    assign o_expired = (TIMEOUT != 0) && (r_cnt == LAST);

endmodule

// File: rtl/apb_slave_router.sv
// APB slave router: decodes one master transfer onto RATIO slave PSELs,
// returns the selected slave's response, and adds decode/timeout errors.
module apb_slave_router
    import apb_router_pkg::*;
#(
    parameter int RATIO    = 4,
    parameter int logRATIO = 2,
    parameter int DATA_W   = 32,
    parameter int TIMEOUT  = 16,
    parameter int TO_W     = 5
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_psel,
    input  logic                       i_penable,
    input  logic [logRATIO-1:0]        i_slv_sel,
    input  logic [RATIO-1:0]           i_slv_en,
    output logic [RATIO-1:0]           o_psel,
    input  logic [RATIO-1:0]           i_pready,
    input  logic [RATIO-1:0]           i_pslverr,
    input  logic [RATIO*DATA_W-1:0]    i_prdata,
    output logic                       o_pready,
    output logic                       o_pslverr,
    output logic [DATA_W-1:0]          o_prdata,
    output logic                       o_timeout,
    output logic                       o_busy
);

    state_t              r_state;
    state_t              w_state_next;
    logic [logRATIO-1:0] r_sel;

    logic                w_valid;
    logic                w_setup;
    logic                w_expired;
    logic                w_inc;
    logic                w_clear;
    logic [RATIO-1:0]    w_hit;
    logic [RATIO-1:0]    w_psel_idle;
    logic [DATA_W-1:0]   w_slot_data [RATIO];
    logic                w_sel_pready;
    logic                w_sel_pslverr;
    logic [DATA_W-1:0]   w_sel_prdata;

    assign w_valid = slot_valid(32'(i_slv_sel), RATIO, 32'(i_slv_en));
    assign w_setup = i_psel & ~i_penable;

    for (genvar gi = 0; gi < RATIO; gi++) begin : g_slot
        assign w_hit[gi]       = (r_sel == logRATIO'(gi));
        assign w_psel_idle[gi] = i_psel & w_valid & (i_slv_sel == logRATIO'(gi));
        assign w_slot_data[gi] = i_prdata[gi*DATA_W +: DATA_W];
    end

    // AND-OR mux keyed on the registered selection, one-hot by construction.
    always_comb begin
        w_sel_pready  = |(i_pready & w_hit);
        w_sel_pslverr = |(i_pslverr & w_hit);
        w_sel_prdata  = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (w_hit[k]) begin
                w_sel_prdata = w_sel_prdata | w_slot_data[k];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_setup) begin
                    w_state_next = w_valid ? ST_ACCESS : ST_ERR;
                end
            end
            ST_ACCESS: begin
                if (!i_psel || w_sel_pready) begin
                    w_state_next = ST_IDLE;
                end else if (w_expired) begin
                    w_state_next = ST_TOUT;
                end
            end
            ST_ERR: begin
                if (!i_psel || i_penable) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_TOUT: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == ST_IDLE) && w_setup && w_valid) begin
                r_sel <= i_slv_sel;
            end
        end
    end

    // Count only genuine wait cycles; every other cycle leaves cnt at zero.
    assign w_inc   = (r_state == ST_ACCESS) & i_psel & ~w_sel_pready & ~w_expired;
    assign w_clear = ~w_inc;

    apb_to_counter #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_to_cnt (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_clear),
        .i_inc     (w_inc),
        .o_expired (w_expired)
    );

    always_comb begin
        o_psel    = '0;
        o_pready  = 1'b0;
        o_pslverr = 1'b0;
        o_prdata  = '0;
        o_timeout = 1'b0;
        o_busy    = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: o_psel = w_psel_idle;
            ST_ACCESS: begin
                if (i_psel) begin
                    o_psel    = w_hit;
                    o_pready  = w_sel_pready;
                    o_pslverr = w_sel_pslverr & w_sel_pready;
                    o_prdata  = w_sel_pready ? w_sel_prdata : '0;
                end
            end
            ST_ERR: begin
                if (i_psel && i_penable) begin
                    o_pready  = 1'b1;
                    o_pslverr = 1'b1;
                end
            end
            ST_TOUT: begin
                if (i_psel) begin
                    o_pready  = 1'b1;
                    o_pslverr = 1'b1;
                    o_timeout = 1'b1;
                end
            end
            default: ;
        endcase
        if (!i_rst_n) begin
            o_psel    = '0;
            o_pready  = 1'b0;
            o_pslverr = 1'b0;
            o_prdata  = '0;
            o_timeout = 1'b0;
            o_busy    = 1'b0;
        end
    end

endmodule
